// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_t;

  // Round-robin scan: first requester found starting at ptr, wrapping mod NUM_REQ.
  // Offsets are walked from far to near so the nearest hit is the one kept.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the 4 masters and the arbiter.
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  // Requester side.
  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/onehot_dec2to4.sv
// Combinational 2-to-4 one-hot decoder.
module onehot_dec2to4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  // Exactly one output bit set for every index value.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with hold-until-release grants.
// Optional watchdog on the grant hold time: define ARB_TIMEOUT_EN.
//
//  state    | meaning
//  ---------+-------------------------------------------------------
//  ST_IDLE  | no grant; samples req and picks a winner from ptr
//  ST_GRANT | one master owns the resource until done/req drop/forced
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_4_if.slave arb
);

  // Hold counter must be able to reach MAX_HOLD-1.
  if ((MAX_HOLD < 1) || (MAX_HOLD >= (1 << CNT_W))) begin : g_bad_cfg
    $error("rr_arbiter_4: MAX_HOLD must be in 1 .. 2**CNT_W-1");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [IDX_W-1:0]   winner;
  logic [NUM_REQ-1:0] onehot_nxt;
  logic               owner_rel;
  logic               forced;

  assign winner    = rr_pick(arb.req, ptr_q);
  assign owner_rel = arb.done | ~arb.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog fires on the last permitted hold cycle unless the owner lets go itself.
  assign forced = (state_q == ST_GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1)) && !owner_rel;
`else
  assign forced = 1'b0;
`endif

  // Decode the next owner so gnt is registered alongside gnt_idx.
  onehot_dec2to4 u_dec (
    .idx    (gnt_idx_d),
    .onehot (onehot_nxt)
  );

  // Next-state logic for the arbitration FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|arb.req) begin
          state_d     = ST_GRANT;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          ptr_d       = winner + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (owner_rel || forced) begin
          state_d     = ST_IDLE;
          gnt_valid_d = 1'b0;
          timeout_d   = forced;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
    gnt_d = gnt_valid_d ? onehot_nxt : '0;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter, restarted on every new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = gnt_idx_q;
  assign arb.gnt_valid = gnt_valid_q;
  assign arb.timeout   = timeout_q;

endmodule
